// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared constants, FSM state type and limb helper for add_seq_ctrl.
// Optional subtract mode is enabled in add_seq_ctrl by defining ADD_SEQ_SUB_EN.
package add_seq_pkg;

    localparam int LIMB_W    = 16;
    localparam int MAX_WORDS = 16;
    localparam int VEC_W     = LIMB_W * MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limb k of a vector zero-extended to the widest legal operand.
    function automatic logic [LIMB_W-1:0] limb(
        input logic [VEC_W-1:0] v,
        input logic [31:0]      k
    );
        return LIMB_W'(v >> (k * LIMB_W));
    endfunction

endpackage

// File: rtl/add_seq_ctrl_add16.sv
// add16_unit: combinational 16-bit adder that also exposes the carry into bit 15.
// Shared limb adder of add_seq_ctrl (ADD_SEQ_SUB_EN selects subtract in the parent).
module add16_unit
    import add_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              c_in,
    output logic [LIMB_W-1:0] sum,
    output logic              c_out,
    output logic              c15
);

    logic [LIMB_W-1:0] low;
    logic [1:0]        high;

    // Split at the sign bit so the carry into it is visible for overflow.
    assign low  = {1'b0, a[LIMB_W-2:0]}
                + {1'b0, b[LIMB_W-2:0]}
                + {{(LIMB_W-1){1'b0}}, c_in};
    assign c15  = low[LIMB_W-1];
    assign high = {1'b0, a[LIMB_W-1]}
                + {1'b0, b[LIMB_W-1]}
                + {1'b0, c15};

    assign sum   = {high[0], low[LIMB_W-2:0]};
    assign c_out = high[1];

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: WORDS x 16-bit add sequenced one limb per cycle through add16_unit.
// Define ADD_SEQ_SUB_EN to add the sub port (A - B via inverted B and forced carry).
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [LIMB_W*WORDS-1:0] a,
    input  logic [LIMB_W*WORDS-1:0] b,
    input  logic                    c_in,
`ifdef ADD_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LIMB_W*WORDS-1:0] sum,
    output logic                    c_out,
    output logic                    ovf
);

    localparam int W     = LIMB_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic [W-1:0]      sum_q;
    logic [IDX_W-1:0]  idx_q;
    logic              carry_q;
    logic              c_out_q;
    logic              ovf_q;

    logic [W-1:0]      b_load;
    logic              c_load;
    logic              accept;
    logic              release_resp;
    logic              last;
    logic [LIMB_W-1:0] limb_a;
    logic [LIMB_W-1:0] limb_b;
    logic [LIMB_W-1:0] limb_s;
    logic              add_co;
    logic              add_c15;

`ifdef ADD_SEQ_SUB_EN
    // Two's complement subtract: A + ~B + 1, so c_in is ignored.
    assign b_load = sub ? ~b : b;
    assign c_load = sub | c_in;
`else
    assign b_load = b;
    assign c_load = c_in;
`endif

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == DONE);
    assign accept       = req_valid & req_ready;
    assign release_resp = resp_valid & resp_ready;
    assign last         = (idx_q == LAST);

    assign limb_a = limb(VEC_W'(op_a), 32'(idx_q));
    assign limb_b = limb(VEC_W'(op_b), 32'(idx_q));

    add16_unit u_add (
        .a     (limb_a),
        .b     (limb_b),
        .c_in  (carry_q),
        .sum   (limb_s),
        .c_out (add_co),
        .c15   (add_c15)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (release_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= b_load;
            carry_q <= c_load;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            for (int k = 0; k < WORDS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    sum_q[k*LIMB_W +: LIMB_W] <= limb_s;
                end
            end
            carry_q <= add_co;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                c_out_q <= add_co;
                ovf_q   <= add_c15 ^ add_co;
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: scoreboard bench for add_seq_ctrl with WORDS=4.
// Subtract vectors run only when ADD_SEQ_SUB_EN is defined.
module tb_add_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    always #5 clk = ~clk;

    add_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a          (a),
        .b          (b),
        .c_in       (c_in),
`ifdef ADD_SEQ_SUB_EN
        .sub        (sub),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .sum        (sum),
        .c_out      (c_out),
        .ovf        (ovf)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t q[$];
    int   acc_cyc[$];
    int   hs_cyc = -1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) acc_cyc.push_back(cyc);
            if (resp_valid && resp_ready) begin
                exp_t e;
                hs_cyc = cyc;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got sum %h expected no response", sum);
                end else begin
                    e = q.pop_front();
                    chk("resp_sum", sum, e.s);
                    chk("resp_c_out", W'(c_out), W'(e.co));
                    chk("resp_ovf", W'(ovf), W'(e.ov));
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic sb,
                         input logic [W-1:0] es, input logic eco, input logic eov);
        int n;
        a = av;
        b = bv;
        c_in = ci;
`ifdef ADD_SEQ_SUB_EN
        sub = sb;
`else
        if (sb) $display("note: subtract vector issued without subtract mode");
`endif
        req_valid = 1'b1;
        q.push_back(exp_t'{es, eco, eov});
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", W'(req_ready), W'(1));
        chk("rst_resp_valid", W'(resp_valid), W'(0));
        chk("rst_sum", sum, '0);
        chk("rst_c_out", W'(c_out), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-run: no response must appear
        a = 64'h1;
        b = 64'h2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", W'(resp_valid), W'(0));
        chk("midrst_sum", sum, '0);
        chk("midrst_req_ready", W'(req_ready), W'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_resp_valid", W'(resp_valid), W'(0));
        chk("post_rst_req_ready", W'(req_ready), W'(1));

        // Carry ripple through every limb
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        req_valid = 1'b0;
        drain();
        // Signed overflow
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1);
        req_valid = 1'b0;
        drain();
        // Carry in used
        issue(64'h1234, 64'h1_EDCC, 1'b1, 1'b0, 64'h2_0001, 1'b0, 1'b0);
        req_valid = 1'b0;
        drain();

        // Stall in DONE with a second request waiting
        resp_ready = 1'b0;
        issue(64'd5, 64'd6, 1'b0, 1'b0, 64'd11, 1'b0, 1'b0);
        a = 64'd7;
        b = 64'd8;
        q.push_back(exp_t'{64'd15, 1'b0, 1'b0});
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_resp_valid_rise", W'(resp_valid), W'(1));
        acc_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_sum", sum, 64'd11);
            chk("stall_c_out", W'(c_out), W'(0));
            chk("stall_ovf", W'(ovf), W'(0));
            chk("stall_req_ready", W'(req_ready), W'(0));
            chk("stall_resp_valid", W'(resp_valid), W'(1));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("stall_accept_count", W'(acc_cyc.size()), W'(1));
        if (acc_cyc.size() >= 1)
            chk("stall_accept_gap", W'(acc_cyc[0] - hs_cyc), W'(1));
        drain();

        // Back-to-back with req_valid and resp_ready held high
        acc_cyc.delete();
        issue(64'd100, 64'd200, 1'b0, 1'b0, 64'd300, 1'b0, 1'b0);
        issue(64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
              64'h0, 1'b1, 1'b1);
        req_valid = 1'b0;
        drain();
        chk("b2b_accept_count", W'(acc_cyc.size()), W'(3));
        if (acc_cyc.size() == 3) begin
            chk("b2b_gap_1", W'(acc_cyc[1] - acc_cyc[0]), W'(WORDS + 2));
            chk("b2b_gap_2", W'(acc_cyc[2] - acc_cyc[1]), W'(WORDS + 2));
        end

`ifdef ADD_SEQ_SUB_EN
        issue(64'h1_0000, 64'h1, 1'b0, 1'b1, 64'hFFFF, 1'b1, 1'b0);
        req_valid = 1'b0;
        drain();
        issue(64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        req_valid = 1'b0;
        drain();
        issue(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        req_valid = 1'b0;
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
